// File: rtl/scan_frame_checker.sv
// Deserialises an MSB-first scan stream into a WIDTH-bit frame and checks it against a latched golden pattern.
// Optional idle timeout in SHIFT is compiled in with `define SCAN_FRAME_CHECKER_TIMEOUT_EN.
module scan_frame_checker #(
  parameter int unsigned WIDTH   = 192,
  parameter int unsigned ERR_W   = 8,
  parameter int unsigned FCNT_W  = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  golden,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  data_out,
  output logic              match,
  output logic [ERR_W-1:0]  err_bits,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [FCNT_W-1:0] fail_cnt
`ifdef SCAN_FRAME_CHECKER_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef SCAN_FRAME_CHECKER_TIMEOUT_EN
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]    golden_q, golden_d;
  logic [WIDTH-1:0]    data_d;
  logic [ERR_W-1:0]    err_d;
  logic                match_d;
  logic                busy_d;
  logic                done_d;
  logic [FCNT_W-1:0]   frame_d;
  logic [FCNT_W-1:0]   fail_d;
`ifdef SCAN_FRAME_CHECKER_TIMEOUT_EN
  logic [TO_W-1:0]     idle_q, idle_d;
  logic                timeout_d;
`endif

  function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
    return (v == '1) ? v : v + FCNT_W'(1);
  endfunction

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      golden_q  <= '0;
      data_out  <= '0;
      err_bits  <= '0;
      match     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      fail_cnt  <= '0;
`ifdef SCAN_FRAME_CHECKER_TIMEOUT_EN
      idle_q    <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      golden_q  <= golden_d;
      data_out  <= data_d;
      err_bits  <= err_d;
      match     <= match_d;
      busy      <= busy_d;
      done      <= done_d;
      frame_cnt <= frame_d;
      fail_cnt  <= fail_d;
`ifdef SCAN_FRAME_CHECKER_TIMEOUT_EN
      idle_q    <= idle_d;
      timeout   <= timeout_d;
`endif
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    golden_d  = golden_q;
    data_d    = data_out;
    err_d     = err_bits;
    match_d   = match;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    frame_d   = frame_cnt;
    fail_d    = fail_cnt;
`ifdef SCAN_FRAME_CHECKER_TIMEOUT_EN
    idle_d    = idle_q;
    timeout_d = timeout;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          golden_d = golden;
          idx_d    = IDX_W'(WIDTH - 1);
          err_d    = '0;
          match_d  = 1'b0;
          busy_d   = 1'b1;
`ifdef SCAN_FRAME_CHECKER_TIMEOUT_EN
          idle_d    = '0;
          timeout_d = 1'b0;
`endif
        end
      end

      SHIFT: begin
        busy_d = 1'b1;
        if (bit_valid) begin
          data_d = {data_out[WIDTH-2:0], bit_in};
          if ((bit_in != golden_q[idx_q]) && (err_bits != '1)) begin
            err_d = err_bits + ERR_W'(1);
          end
          idx_d = idx_q - IDX_W'(1);
`ifdef SCAN_FRAME_CHECKER_TIMEOUT_EN
          idle_d = '0;
`endif
          // Last bit of the frame: results become visible together with done
          if (idx_q == '0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = (err_d == '0);
            frame_d = sat_inc(frame_cnt);
            if (err_d != '0) begin
              fail_d = sat_inc(fail_cnt);
            end
          end
        end
`ifdef SCAN_FRAME_CHECKER_TIMEOUT_EN
        else if (idle_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          match_d   = 1'b0;
          timeout_d = 1'b1;
          idle_d    = '0;
          frame_d   = sat_inc(frame_cnt);
          fail_d    = sat_inc(fail_cnt);
        end else begin
          idle_d = idle_q + TO_W'(1);
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_frame_checker.sv
// Randomised self-checking bench for scan_frame_checker against a frame-level reference model.
module tb_scan_frame_checker;
  localparam int unsigned WIDTH  = 192;
  localparam int unsigned ERR_W  = 8;
  localparam int unsigned FCNT_W = 16;
  localparam int unsigned TO_LIM = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [WIDTH-1:0]  golden;
  logic              bit_valid;
  logic              bit_in;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  data_out;
  logic              match;
  logic [ERR_W-1:0]  err_bits;
  logic [FCNT_W-1:0] frame_cnt;
  logic [FCNT_W-1:0] fail_cnt;
`ifdef SCAN_FRAME_CHECKER_TIMEOUT_EN
  logic              timeout;
`endif

  int total = 0;
  int bad   = 0;
  int exp_frames = 0;
  int exp_fails  = 0;

  scan_frame_checker #(
    .WIDTH(WIDTH), .ERR_W(ERR_W), .FCNT_W(FCNT_W), .TIMEOUT(TO_LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .golden(golden),
    .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy), .done(done),
    .data_out(data_out), .match(match), .err_bits(err_bits),
    .frame_cnt(frame_cnt), .fail_cnt(fail_cnt)
`ifdef SCAN_FRAME_CHECKER_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rand_vec();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Feed one frame MSB-first; gaps insert idle cycles, poke pulses start and churns golden while shifting
  task automatic run_frame(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] f,
                           input bit gaps, input bit poke);
    int early;
    int errs;
    early = 0;
    golden = g; start = 1'b1; bit_valid = 1'b0;
    step();
    start = 1'b0;
    chk("busy_on", busy, 1);
    golden = rand_vec();
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 5);
        for (int k = 0; k < n; k++) begin
          bit_valid = 1'b0;
          bit_in = 1'($urandom);
          if (poke) begin
            start  = 1'($urandom);
            golden = rand_vec();
          end
          step();
          early += int'(done);
        end
      end
      start = poke ? 1'($urandom) : 1'b0;
      bit_valid = 1'b1;
      bit_in = f[i];
      step();
      if (i != 0) early += int'(done);
    end
    // Extra valid bit while in DONE must be ignored
    start = 1'b0;
    bit_valid = 1'b1;
    bit_in = ~f[0];
    errs = $countones(f ^ g);
    if (errs > 255) errs = 255;
    exp_frames++;
    if (errs != 0) exp_fails++;
    chk("done_pulse", done, 1);
    chk("no_early_done", early, 0);
    chk("busy_off", busy, 0);
    chk("data_out", data_out, f);
    chk("match", match, (errs == 0));
    chk("err_bits", err_bits, errs);
    step();
    bit_valid = 1'b0;
    chk("done_single", done, 0);
    chk("data_hold", data_out, f);
    chk("match_hold", match, (errs == 0));
    chk("frame_cnt", frame_cnt, exp_frames);
    chk("fail_cnt", fail_cnt, exp_fails);
  endtask

  initial begin
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] m;
    rst_n = 1'b0; start = 1'b0; golden = '0; bit_valid = 1'b0; bit_in = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", data_out, 0);
    chk("rst_match", match, 0);
    chk("rst_err", err_bits, 0);
    chk("rst_frames", frame_cnt, 0);
    chk("rst_fails", fail_cnt, 0);
    rst_n = 1'b1;
    step();

    g = '0; g[7:0] = 8'hA5;
    run_frame(g, g, 1'b0, 1'b0);

    f = g; f[191] = ~f[191]; f[100] = ~f[100]; f[0] = ~f[0];
    run_frame(g, f, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      g = rand_vec();
      m = '0;
      if (t % 3 != 0) begin
        for (int b = 0; b < int'($urandom_range(1, 12)); b++) m[$urandom_range(0, WIDTH - 1)] = 1'b1;
      end
      run_frame(g, g ^ m, 1'b1, (t >= 3));
    end

    // Abort a frame with reset after 100 bits
    g = rand_vec();
    golden = g; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bit_valid = 1'b1; bit_in = 1'($urandom);
      step();
    end
    bit_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_err", err_bits, 0);
    chk("mid_rst_frames", frame_cnt, 0);
    chk("mid_rst_fails", fail_cnt, 0);
    rst_n = 1'b1;
    exp_frames = 0;
    exp_fails  = 0;
    step();
    g = rand_vec();
    run_frame(g, g, 1'b1, 1'b0);

`ifdef SCAN_FRAME_CHECKER_TIMEOUT_EN
    begin
      int cyc;
      g = rand_vec();
      golden = g; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
        bit_valid = 1'b1; bit_in = g[WIDTH - 1 - i];
        step();
      end
      bit_valid = 1'b0;
      cyc = 0;
      for (int c = 1; c <= 3 * TO_LIM; c++) begin
        step();
        if (done) begin
          cyc = c;
          break;
        end
      end
      exp_frames++;
      exp_fails++;
      chk("to_cycles", cyc, TO_LIM);
      chk("to_flag", timeout, 1);
      chk("to_match", match, 0);
      step();
      chk("to_frames", frame_cnt, exp_frames);
      chk("to_fails", fail_cnt, exp_fails);
      chk("to_hold", timeout, 1);
      golden = g; start = 1'b1;
      step();
      start = 1'b0;
      chk("to_clear", timeout, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scan_frame_checker.md
Name: scan_frame_checker

Overview:
- Downstream stage of the 192-bit parallel-load / serial-shift register file in the self-test chain.
- Deserialises the MSB-first bit stream that the register file shifts out back into a WIDTH-bit frame.
- Compares the frame bit-by-bit against a golden pattern and reports pass/fail, mismatch count and a frame tally to the self-test controller.

Parameters:
- WIDTH, 192, frame length in bits; must equal the upstream register file width.
- ERR_W, 8, width of the mismatch counter; must satisfy 2^ERR_W > WIDTH.
- FCNT_W, 16, width of the completed-frame and failed-frame counters.
- TIMEOUT, 1023, idle-cycle limit in SHIFT; used only when the optional feature is compiled in.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- start  input  1  one-cycle request to capture a frame; honoured only in IDLE.
- golden  input  WIDTH  expected frame; sampled into an internal register on the accepted start.
- bit_valid  input  1  bit_in carries a stream bit this cycle.
- bit_in  input  1  serial stream bit, MSB of frame first (connects to upstream shift_out).
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse at frame completion.
- data_out  output  WIDTH  captured frame; bit WIDTH-1 is the first bit received.
- match  output  1  captured frame equals golden; valid from done, held until next accepted start.
- err_bits  output  ERR_W  number of mismatching bits in the frame; held like match.
- frame_cnt  output  FCNT_W  completed frames since reset, saturating.
- fail_cnt  output  FCNT_W  completed frames with match=0, saturating.

Behaviour:
- Reset: on posedge with rst_n=0, state goes to IDLE. Reset values: busy=0, done=0, data_out=0, match=0, err_bits=0, frame_cnt=0, fail_cnt=0. Internal bit index and golden register are cleared. Reset mid-frame discards the partial frame and does not count it.
- States:
  - IDLE: start=1 moves to SHIFT. On that edge: golden is latched, bit index is set to WIDTH-1, err_bits and match are cleared. bit_valid is ignored in IDLE.
  - SHIFT: each cycle with bit_valid=1:
    - shift data_out left, with bit_in entering bit 0;
    - compare bit_in with golden_q[index]; on mismatch, err_bits increments, saturating at 2^ERR_W-1;
    - decrement index.
    - Cycles with bit_valid=0 hold all state.
    - When the bit accepted has index 0, move to DONE.
  - DONE: held for one cycle. done=1, match=(err_bits==0), frame_cnt increments, fail_cnt increments if match=0. Both counters saturate at all-ones. Next state is IDLE.
- start is ignored in SHIFT and DONE; no queuing. start in IDLE in the cycle right after DONE is accepted normally.
- Latency: done is high in the cycle after the edge that accepts the WIDTH-th valid bit. data_out, match and err_bits are stable in that same cycle.
- Exactly WIDTH valid bits are consumed per frame. Extra valid bits after completion are ignored.
- golden changes after the accepted start have no effect on the current frame.

Optional Feature:
- Macro SCAN_FRAME_CHECKER_TIMEOUT_EN.
- Defined:
  - Adds output timeout (1 bit, reset 0) and an idle counter.
  - In SHIFT, the idle counter counts consecutive cycles with bit_valid=0 and resets to 0 on any valid bit.
  - When the counter reaches TIMEOUT, go to DONE with timeout=1, match=0, counted as a failed frame.
  - timeout is held until the next accepted start clears it.
- Not defined: no timeout port and no counter; SHIFT waits indefinitely for bits.

Test Plan:
- Reset, then golden=192'h0…0A5, start, 192 valid bits equal to golden MSB-first -> done high exactly 1 cycle after the 192nd bit; data_out=golden, match=1, err_bits=0, frame_cnt=1, fail_cnt=0.
- Same frame with bits 191, 100 and 0 flipped -> match=0, err_bits=3, fail_cnt=1, data_out shows those three bits inverted.
- Valid bits with bit_valid=0 gaps of 1-5 cycles inserted randomly -> results identical to the gap-free run; done still fires after the 192nd valid bit.
- start pulsed in SHIFT, plus golden changed mid-frame -> no restart, frame compared against the latched golden, single done.
- rst_n low for 1 cycle after 100 bits, then a full new frame -> all outputs 0 after the reset edge, frame_cnt=1 after the new frame (partial frame not counted).
- With SCAN_FRAME_CHECKER_TIMEOUT_EN and TIMEOUT=20: start, 10 bits, then bit_valid=0 -> done and timeout=1 after 20 idle cycles, fail_cnt=1; next start clears timeout.
